// File: rtl/resnet_pkg.sv
// Shared definitions for the residual accumulator.
//   FM_DEPTH_DEF / FM_WIDTH_DEF : default channels per pixel and pixels per row
//   DATA_W                      : width of one channel value
//   state_t                     : frame-tracking FSM states
//   relu_sat()                  : clamps a 17-bit signed value into an unsigned activation
package resnet_pkg;

  localparam int FM_DEPTH_DEF = 64;
  localparam int FM_WIDTH_DEF = 56;
  localparam int DATA_W       = 16;
  localparam int MAX_ACT      = 2 ** (DATA_W - 1) - 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Negative values become 0 and anything above the signed 16-bit maximum
  // saturates, so the result always fits the next layer's 15-bit magnitude range.
  function automatic logic [DATA_W-1:0] relu_sat(input logic signed [DATA_W:0] v);
    if (v < 0) begin
      return '0;
    end else if (v > MAX_ACT) begin
      return DATA_W'(MAX_ACT);
    end
    return v[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/res_accum_if.sv
// Data-path bundle between the macro/residual sources and the accumulator.
//   res_valid / res_in        : residual vector push strobe and data
//   adc_valid / adc_data      : macro result strobe and data
//   data_out_valid / data_out : registered activation output
// slave  = accumulator side, master = producer/consumer side.
interface res_accum_if import resnet_pkg::*; #(
  parameter int FM_DEPTH = FM_DEPTH_DEF
) ();

  logic                           res_valid;
  logic [FM_DEPTH-1:0][DATA_W-1:0] res_in;
  logic                           adc_valid;
  logic [FM_DEPTH-1:0][DATA_W-1:0] adc_data;
  logic                           data_out_valid;
  logic [FM_DEPTH-1:0][DATA_W-1:0] data_out;

  modport slave (
    input  res_valid, res_in, adc_valid, adc_data,
    output data_out_valid, data_out
  );

  modport master (
    output res_valid, res_in, adc_valid, adc_data,
    input  data_out_valid, data_out
  );

endinterface

// File: rtl/res_fifo.sv
// Residual vector FIFO with same-cycle bypass.
//   clk, rstn : clock, asynchronous active-low reset
//   flush     : discard all stored vectors
//   push/din  : write request and residual vector
//   pop       : read request (one per macro result)
//   dout      : residual to use this cycle (head, bypassed din, or zero)
//   ovf / udf : single-cycle overflow / underflow strobes
module res_fifo import resnet_pkg::*; #(
  parameter int DEPTH    = 4,
  parameter int FM_DEPTH = FM_DEPTH_DEF
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            flush,
  input  logic                            push,
  input  logic                            pop,
  input  logic [FM_DEPTH-1:0][DATA_W-1:0] din,
  output logic [FM_DEPTH-1:0][DATA_W-1:0] dout,
  output logic                            ovf,
  output logic                            udf
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [FM_DEPTH-1:0][DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic empty, full, bypass, do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(DEPTH));
  // Push and pop into an empty FIFO hands din straight through; nothing is stored.
  assign bypass  = push & pop & empty;
  assign do_pop  = pop & ~empty;
  // When full, a simultaneous pop frees the slot before the push lands.
  assign do_push = push & ~bypass & (~full | pop);
  assign ovf     = push & full & ~pop;
  assign udf     = pop & empty & ~push;

  assign dout = bypass ? din : (empty ? '0 : mem[rd_ptr_reg]);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= next_ptr(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= next_ptr(rd_ptr_reg);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/res_accum.sv
// Residual accumulator: adds a buffered residual vector to each macro result,
// shifts, applies ReLU/saturation and tracks frame boundaries.
//   clk, rstn        : clock, asynchronous active-low reset
//   verticle_sync    : 1 = blanking, 0 = frame active
//   mode_in          : 1 = add residual, 0 = residual treated as zero
//   bus              : residual/macro inputs and activation output
//   vs_next          : frame sync for the next stage
//   frame_done       : pulse with the last pixel of a frame
//   err_ovf, err_udf : sticky FIFO overflow / underflow flags
module res_accum import resnet_pkg::*; #(
  parameter int FM_DEPTH   = FM_DEPTH_DEF,
  parameter int FM_WIDTH   = FM_WIDTH_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int SHIFT      = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        verticle_sync,
  input  logic        mode_in,
  res_accum_if.slave  bus,
  output logic        vs_next,
  output logic        frame_done,
  output logic        err_ovf,
  output logic        err_udf
);

  localparam logic [11:0] LAST_PIXEL = 12'(FM_WIDTH * FM_WIDTH - 1);

  state_t      state_reg;
  logic        mode_reg;
  logic [11:0] pix_cnt_reg;
  logic        data_out_valid_reg, frame_done_reg, vs_next_reg;
  logic        err_ovf_reg, err_udf_reg;
  logic [FM_DEPTH-1:0][DATA_W-1:0] data_out_reg, res_vec, result_next;
  logic        active, push, pop, flush, ovf_pulse, udf_pulse;

  // A sync rise while running aborts the frame in that same cycle; any strobes
  // arriving alongside it are dropped.
  assign active = (state_reg == RUN) & ~verticle_sync;
  assign flush  = (state_reg == RUN) & verticle_sync;
  assign push   = bus.res_valid & active;
  assign pop    = bus.adc_valid & active;

  res_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .FM_DEPTH(FM_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rstn (rstn),
    .flush(flush),
    .push (push),
    .pop  (pop),
    .din  (bus.res_in),
    .dout (res_vec),
    .ovf  (ovf_pulse),
    .udf  (udf_pulse)
  );

  generate
    for (genvar gi = 0; gi < FM_DEPTH; gi++) begin : g_lane
      logic signed [DATA_W:0] adc_ext, res_ext, total;
      assign adc_ext = {bus.adc_data[gi][DATA_W-1], bus.adc_data[gi]};
      assign res_ext = mode_reg ? {res_vec[gi][DATA_W-1], res_vec[gi]} : '0;
      // 17 bits hold the full sum of two 16-bit signed values without wrap.
      assign total   = adc_ext + res_ext;
      assign result_next[gi] = relu_sat(total >>> SHIFT);
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg          <= IDLE;
      mode_reg           <= 1'b0;
      pix_cnt_reg        <= '0;
      data_out_reg       <= '0;
      data_out_valid_reg <= 1'b0;
      frame_done_reg     <= 1'b0;
      vs_next_reg        <= 1'b1;
      err_ovf_reg        <= 1'b0;
      err_udf_reg        <= 1'b0;
    end else begin
      data_out_valid_reg <= 1'b0;
      frame_done_reg     <= 1'b0;
      // The frame ends in IDLE with vs_next still low; it rises one cycle later.
      if (frame_done_reg) vs_next_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (!verticle_sync) begin
            state_reg <= RUN;
            mode_reg  <= mode_in;
          end
        end
        RUN: begin
          if (verticle_sync) begin
            state_reg   <= IDLE;
            pix_cnt_reg <= '0;
            vs_next_reg <= 1'b1;
          end else if (pop) begin
            data_out_valid_reg <= 1'b1;
            data_out_reg       <= result_next;
            vs_next_reg        <= 1'b0;
            if (pix_cnt_reg == LAST_PIXEL) begin
              pix_cnt_reg    <= '0;
              frame_done_reg <= 1'b1;
              state_reg      <= IDLE;
            end else begin
              pix_cnt_reg <= pix_cnt_reg + 12'd1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
      if (ovf_pulse) err_ovf_reg <= 1'b1;
      if (udf_pulse) err_udf_reg <= 1'b1;
    end
  end

  assign bus.data_out_valid = data_out_valid_reg;
  assign bus.data_out       = data_out_reg;
  assign vs_next            = vs_next_reg;
  assign frame_done         = frame_done_reg;
  assign err_ovf            = err_ovf_reg;
  assign err_udf            = err_udf_reg;

endmodule

// File: tb/tb_res_accum.sv
module tb_res_accum;

  localparam int FMD    = 64;
  localparam int FRAME  = 56 * 56;
  localparam int FIFO_D = 4;

  typedef logic [FMD-1:0][15:0] vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn, vsync, mode_in, res_valid, adc_valid;
  vec_t res_in, adc_data;
  logic vs_next4, fd4, ovf4, udf4;
  logic vs_next0, fd0, ovf0, udf0;

  res_accum_if #(.FM_DEPTH(FMD)) bus4 ();
  res_accum_if #(.FM_DEPTH(FMD)) bus0 ();

  assign bus4.res_valid = res_valid;
  assign bus4.res_in    = res_in;
  assign bus4.adc_valid = adc_valid;
  assign bus4.adc_data  = adc_data;
  assign bus0.res_valid = res_valid;
  assign bus0.res_in    = res_in;
  assign bus0.adc_valid = adc_valid;
  assign bus0.adc_data  = adc_data;

  res_accum #(.FM_DEPTH(FMD), .FM_WIDTH(56), .FIFO_DEPTH(FIFO_D), .SHIFT(4)) u_dut (
    .clk(clk), .rstn(rstn), .verticle_sync(vsync), .mode_in(mode_in), .bus(bus4),
    .vs_next(vs_next4), .frame_done(fd4), .err_ovf(ovf4), .err_udf(udf4)
  );

  res_accum #(.FM_DEPTH(FMD), .FM_WIDTH(56), .FIFO_DEPTH(FIFO_D), .SHIFT(0)) u_dut0 (
    .clk(clk), .rstn(rstn), .verticle_sync(vsync), .mode_in(mode_in), .bus(bus0),
    .vs_next(vs_next0), .frame_done(fd0), .err_ovf(ovf0), .err_udf(udf0)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: a bounded queue of residuals plus frame bookkeeping.
  bit   m_run, m_mode, m_ovf, m_udf;
  int   m_cnt;
  vec_t q[$];
  bit   exp_valid, exp_fd, exp_vs;
  vec_t exp_do4, exp_do0;

  function automatic vec_t splat(input logic [15:0] v);
    vec_t r;
    for (int c = 0; c < FMD; c++) r[c] = v;
    return r;
  endfunction

  function automatic vec_t rand_vec();
    vec_t r;
    for (int c = 0; c < FMD; c++) begin
      if ($urandom_range(0, 1) == 1) r[c] = 16'($urandom);
      else r[c] = 16'($urandom_range(0, 8191)) - 16'd4096;
    end
    return r;
  endfunction

  // Output = clamp((adc + res) / 2^shift, 0, 32767); truncating division is
  // equivalent to the floor shift here because every negative result clamps to 0.
  function automatic vec_t ref_out(input vec_t a, input vec_t r, input bit use_r, input int sh);
    vec_t o;
    for (int c = 0; c < FMD; c++) begin
      int av, rv, s;
      av = $signed(a[c]);
      rv = use_r ? int'($signed(r[c])) : 0;
      s  = (av + rv) / (1 << sh);
      if (s < 0) s = 0;
      if (s > 32767) s = 32767;
      o[c] = 16'(s);
    end
    return o;
  endfunction

  task automatic model_cycle();
    vec_t r;
    bit   byp;
    if (!rstn) begin
      m_run = 0; m_mode = 0; m_cnt = 0; q.delete(); m_ovf = 0; m_udf = 0;
      exp_valid = 0; exp_fd = 0; exp_vs = 1; exp_do4 = '0; exp_do0 = '0;
      return;
    end
    if (exp_fd) exp_vs = 1'b1;
    exp_valid = 0;
    exp_fd    = 0;
    if (!m_run) begin
      if (!vsync) begin
        m_run  = 1;
        m_mode = mode_in;
      end
    end else if (vsync) begin
      m_run = 0; q.delete(); m_cnt = 0; exp_vs = 1;
    end else begin
      byp = 0;
      if (adc_valid) begin
        if (q.size() > 0) r = q.pop_front();
        else if (res_valid) begin r = res_in; byp = 1; end
        else begin r = '0; m_udf = 1; end
        exp_do4 = ref_out(adc_data, r, m_mode, 4);
        exp_do0 = ref_out(adc_data, r, m_mode, 0);
        exp_valid = 1;
        exp_vs    = 0;
        m_cnt++;
        if (m_cnt == FRAME) begin
          exp_fd = 1; m_cnt = 0; m_run = 0;
        end
      end
      if (res_valid && !byp) begin
        if (q.size() < FIFO_D) q.push_back(res_in);
        else m_ovf = 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [FMD*16-1:0] obs, input logic [FMD*16-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("valid", bus4.data_out_valid, exp_valid);
    chk("frame_done", fd4, exp_fd);
    chk("vs_next", vs_next4, exp_vs);
    chk("err_ovf", ovf4, m_ovf);
    chk("err_udf", udf4, m_udf);
    chk("data_out", bus4.data_out, exp_do4);
    chk("valid_s0", bus0.data_out_valid, exp_valid);
    chk("frame_done_s0", fd0, exp_fd);
    chk("vs_next_s0", vs_next0, exp_vs);
    chk("err_ovf_s0", ovf0, m_ovf);
    chk("err_udf_s0", udf0, m_udf);
    chk("data_out_s0", bus0.data_out, exp_do0);
  endtask

  // Inputs change only at the falling edge; the model consumes them at the rising edge.
  task automatic step();
    @(posedge clk);
    model_cycle();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_in();
    res_valid = 0; adc_valid = 0;
  endtask

  task automatic rand_in();
    res_valid = ($urandom_range(0, 2) == 0);
    adc_valid = ($urandom_range(0, 3) != 0);
    res_in    = rand_vec();
    adc_data  = rand_vec();
  endtask

  initial begin
    int guard;
    int n_out;
    rstn = 0; vsync = 1; mode_in = 0; res_valid = 0; adc_valid = 0;
    res_in = '0; adc_data = '0;

    // Reset state
    step(); step();
    chk("rst_valid", bus4.data_out_valid, 1'b0);
    chk("rst_data", bus4.data_out, '0);
    chk("rst_vs_next", vs_next4, 1'b1);
    chk("rst_flags", {ovf4, udf4, fd4}, 3'b000);
    rstn = 1;
    step();

    // Test 1: basic add
    vsync = 0; mode_in = 1;
    step();
    res_valid = 1; res_in = splat(16'h0100);
    step();
    res_valid = 0; adc_valid = 1; adc_data = splat(16'h0300);
    step();
    chk("t1_valid", bus4.data_out_valid, 1'b1);
    chk("t1_data", bus4.data_out, splat(16'h0040));
    idle_in();
    step();
    chk("t1_hold", bus4.data_out, splat(16'h0040));
    chk("t1_valid_low", bus4.data_out_valid, 1'b0);

    // Test 2: ReLU and saturation
    res_valid = 1; res_in = splat(16'h0010);
    step();
    res_valid = 0; adc_valid = 1; adc_data = splat(16'hFE00);
    step();
    chk("t2_relu", bus4.data_out, splat(16'h0000));
    adc_valid = 0; res_valid = 1; res_in = splat(16'h7FFF);
    step();
    res_valid = 0; adc_valid = 1; adc_data = splat(16'h7FFF);
    step();
    chk("t2_sat_shift0", bus0.data_out, splat(16'h7FFF));
    chk("t2_shift4", bus4.data_out, splat(16'h0FFF));
    idle_in();

    // Test 4: FIFO boundaries
    for (int i = 0; i < FIFO_D; i++) begin
      res_valid = 1; res_in = rand_vec();
      step();
    end
    chk("t4_fill_no_ovf", ovf4, 1'b0);
    res_valid = 1; res_in = rand_vec(); adc_valid = 1; adc_data = rand_vec();
    step();
    chk("t4_full_pushpop", {ovf4, udf4}, 2'b00);
    adc_valid = 0; res_in = rand_vec();
    step();
    chk("t4_ovf", ovf4, 1'b1);
    res_valid = 0;
    for (int i = 0; i < FIFO_D; i++) begin
      adc_valid = 1; adc_data = rand_vec();
      step();
    end
    res_valid = 1; res_in = splat(16'h0100); adc_valid = 1; adc_data = splat(16'h0100);
    step();
    chk("t4_bypass_data", bus4.data_out, splat(16'h0020));
    chk("t4_bypass_no_udf", udf4, 1'b0);
    res_valid = 0; adc_data = splat(16'h0100);
    step();
    chk("t4_udf_data", bus4.data_out, splat(16'h0010));
    chk("t4_udf", udf4, 1'b1);
    idle_in();

    // Abort with residuals still queued
    res_valid = 1; res_in = splat(16'h7000);
    step(); step();
    idle_in(); vsync = 1;
    step();
    chk("abort_vs_next", vs_next4, 1'b1);
    chk("abort_no_fd", fd4, 1'b0);
    chk("abort_flags_kept", {ovf4, udf4}, 2'b11);

    // Test 3: full frame; the first pixel also proves the FIFO was flushed
    vsync = 0; mode_in = 1;
    step();
    adc_valid = 1; adc_data = splat(16'h0100);
    step();
    chk("flushed_res_zero", bus4.data_out, splat(16'h0010));
    chk("t3_vs_fall", vs_next4, 1'b0);
    n_out = 1;
    guard = 0;
    while (!exp_fd && guard < 20000) begin
      rand_in();
      step();
      if (bus4.data_out_valid) n_out++;
      guard++;
    end
    chk("t3_frame_done", fd4, 1'b1);
    chk("t3_out_count", 32'(n_out), 32'(FRAME));
    idle_in();
    step();
    chk("t3_vs_rise", vs_next4, 1'b1);

    // Test 5: bypass mode
    vsync = 1;
    step();
    vsync = 0; mode_in = 0;
    step();
    res_valid = 1; res_in = splat(16'h7FFF);
    step();
    res_valid = 0; adc_valid = 1; adc_data = splat(16'h0100);
    step();
    chk("t5_bypass", bus4.data_out, splat(16'h0010));

    // Test 6: abort after 100 pixels, then a complete frame
    guard = 0;
    while (m_cnt < 100 && guard < 2000) begin
      rand_in();
      step();
      guard++;
    end
    chk("t6_pixels", 32'(m_cnt), 32'd100);
    idle_in(); vsync = 1;
    step();
    chk("t6_no_fd", fd4, 1'b0);
    chk("t6_vs_next", vs_next4, 1'b1);
    vsync = 0; mode_in = 1;
    step();
    n_out = 0;
    guard = 0;
    while (!exp_fd && guard < 20000) begin
      rand_in();
      step();
      if (bus4.data_out_valid) n_out++;
      guard++;
    end
    chk("t6_frame_done", fd4, 1'b1);
    chk("t6_out_count", 32'(n_out), 32'(FRAME));

    // Reset mid-frame aborts with no further output
    guard = 0;
    while (m_cnt < 20 && guard < 2000) begin
      rand_in();
      step();
      guard++;
    end
    rstn = 0; adc_valid = 1; res_valid = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_mid_valid", bus4.data_out_valid, 1'b0);
    end
    chk("rst_mid_data", bus4.data_out, '0);
    chk("rst_mid_state", {vs_next4, ovf4, udf4, fd4}, 4'b1000);
    idle_in(); rstn = 1; vsync = 1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
